// File: rtl/bmp_stream_reader.sv
// bmp_stream_reader: probes SD sectors on a stride for a BMP matching bmp_width/bmp_height, then streams its 24/32bpp pixels as RGB888 or RGB565 (clk, rst, sd_* sector reader, find/ready/state_code/not_found control, write_req handshake, pix_* stream)
module bmp_stream_reader #(
  parameter int unsigned START_SECTOR = 32000,
  parameter int unsigned SEARCH_STRIDE = 8,
  parameter int unsigned MAX_PROBES = 4096,
  parameter bit OUT_RGB565 = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_init_done,
  input  logic        find,
  input  logic [15:0] bmp_width,
  input  logic [15:0] bmp_height,
  output logic        ready,
  output logic [2:0]  state_code,
  output logic        not_found,
  output logic        write_req,
  input  logic        write_req_ack,
  output logic        sd_sec_read,
  output logic [31:0] sd_sec_read_addr,
  input  logic [7:0]  sd_sec_read_data,
  input  logic        sd_sec_read_data_valid,
  input  logic        sd_sec_read_end,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        pix_eol
);
  localparam logic [31:0] BASE = 32'(START_SECTOR) & ~32'(SEARCH_STRIDE - 1);
  typedef enum logic [2:0] {IDLE, FIND, CHECK, FAIL, WAIT_ACK, READ, DONE} state_t;
  state_t st;
  logic [9:0] hcnt;
  logic [15:0] magic, bpp;
  logic [31:0] file_len, data_off, width, height, probes, bcnt, pcnt, col;
  logic [31:0] h_abs, row_pix, total;
  logic [1:0] pad, pad_cnt, comp, last_comp;
  logic [7:0] b_r, g_r;
  logic [4:0] sh;
  logic [3:0] sb;
  logic match;
  assign h_abs = height[31] ? 32'd0 - height : height;
  assign row_pix = (width * 32'(bpp)) >> 3;
  assign pad = 2'd0 - row_pix[1:0];
  assign total = width * h_abs;
  assign last_comp = (bpp == 16'd32) ? 2'd3 : 2'd2;
  assign sh = {hcnt[1:0] - 2'd2, 3'b000};
  assign sb = {hcnt[0], 3'b000};
  assign match = magic == 16'h4D42 && width[15:0] == bmp_width && h_abs[15:0] == bmp_height &&
                 (bpp == 16'd24 || bpp == 16'd32) && data_off >= 32'd54 && data_off < file_len;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      ready <= 1'b0;
      state_code <= 3'd0;
      not_found <= 1'b0;
      write_req <= 1'b0;
      sd_sec_read <= 1'b0;
      sd_sec_read_addr <= BASE;
      pix_valid <= 1'b0;
      pix_data <= 24'd0;
      pix_eol <= 1'b0;
      hcnt <= 10'd0;
      magic <= 16'd0;
      bpp <= 16'd0;
      file_len <= 32'd0;
      data_off <= 32'd0;
      width <= 32'd0;
      height <= 32'd0;
      probes <= 32'd0;
      bcnt <= 32'd0;
      pcnt <= 32'd0;
      col <= 32'd0;
      pad_cnt <= 2'd0;
      comp <= 2'd0;
      b_r <= 8'd0;
      g_r <= 8'd0;
    end else if (!sd_init_done) begin
      st <= IDLE;
      ready <= 1'b0;
      state_code <= 3'd0;
      not_found <= 1'b0;
      write_req <= 1'b0;
      sd_sec_read <= 1'b0;
      sd_sec_read_addr <= BASE;
      pix_valid <= 1'b0;
      pix_eol <= 1'b0;
    end else begin
      not_found <= 1'b0;
      pix_valid <= 1'b0;
      pix_eol <= 1'b0;
      case (st)
        IDLE: begin
          ready <= !find;
          state_code <= find ? 3'd2 : (state_code == 3'd4 ? 3'd4 : 3'd1);
          if (find) begin
            st <= FIND;
            probes <= 32'd0;
            hcnt <= 10'd0;
            sd_sec_read <= 1'b1;
          end
        end
        FIND: begin
          sd_sec_read <= !sd_sec_read_end;
          if (sd_sec_read_data_valid) begin
            hcnt <= hcnt + 10'd1;
            if (hcnt < 10'd2) magic[sb +: 8] <= sd_sec_read_data;
            if (hcnt >= 10'd2 && hcnt <= 10'd5) file_len[sh +: 8] <= sd_sec_read_data;
            if (hcnt >= 10'd10 && hcnt <= 10'd13) data_off[sh +: 8] <= sd_sec_read_data;
            if (hcnt >= 10'd18 && hcnt <= 10'd21) width[sh +: 8] <= sd_sec_read_data;
            if (hcnt >= 10'd22 && hcnt <= 10'd25) height[sh +: 8] <= sd_sec_read_data;
            if (hcnt >= 10'd28 && hcnt <= 10'd29) bpp[sb +: 8] <= sd_sec_read_data;
          end
          if (sd_sec_read_end) st <= CHECK;
        end
        CHECK:
          if (match) begin
            write_req <= 1'b1;
            st <= WAIT_ACK;
          end else if (probes + 32'd1 < 32'(MAX_PROBES)) begin
            probes <= probes + 32'd1;
            sd_sec_read_addr <= sd_sec_read_addr + 32'(SEARCH_STRIDE);
            hcnt <= 10'd0;
            sd_sec_read <= 1'b1;
            st <= FIND;
          end else st <= FAIL;
        FAIL: begin
          not_found <= 1'b1;
          state_code <= 3'd4;
          ready <= 1'b1;
          sd_sec_read_addr <= BASE;
          st <= IDLE;
        end
        WAIT_ACK:
          if (write_req_ack) begin
            write_req <= 1'b0;
            state_code <= 3'd3;
            sd_sec_read <= 1'b1;
            bcnt <= 32'd0;
            pcnt <= 32'd0;
            col <= 32'd0;
            pad_cnt <= 2'd0;
            comp <= 2'd0;
            st <= READ;
          end
        READ: begin
          sd_sec_read <= !sd_sec_read_end;
          if (sd_sec_read_data_valid) begin
            bcnt <= bcnt + 32'd1;
            if (bcnt >= data_off && pcnt != total) begin
              if (pad_cnt != 2'd0) pad_cnt <= pad_cnt - 2'd1;
              else begin
                comp <= comp + 2'd1;
                if (comp == 2'd0) b_r <= sd_sec_read_data;
                if (comp == 2'd1) g_r <= sd_sec_read_data;
                if (comp == 2'd2)
                  pix_data <= OUT_RGB565 ? {8'd0, sd_sec_read_data[7:3], g_r[7:2], b_r[7:3]}
                                         : {sd_sec_read_data, g_r, b_r};
                if (comp == last_comp) begin
                  comp <= 2'd0;
                  pix_valid <= 1'b1;
                  pix_eol <= col == width - 32'd1;
                  pcnt <= pcnt + 32'd1;
                  col <= (col == width - 32'd1) ? 32'd0 : col + 32'd1;
                  if (col == width - 32'd1) pad_cnt <= pad;
                end
              end
            end
          end
          if (sd_sec_read_end) begin
            sd_sec_read_addr <= sd_sec_read_addr + 32'd1;
            if (pcnt == total || bcnt >= file_len) st <= DONE;
          end
        end
        DONE: begin
          sd_sec_read <= 1'b0;
          sd_sec_read_addr <= BASE;
          state_code <= 3'd1;
          ready <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bmp_stream_reader.sv
// tb_bmp_stream_reader: scoreboard bench driving an SD sector model into two bmp_stream_reader configurations
module tb_bmp_stream_reader;
  logic clk = 1'b0, rst = 1'b1, init = 1'b0;
  always #5 clk = ~clk;
  logic find0 = 1'b0, find1 = 1'b0, ack0 = 1'b0, ack1 = 1'b0;
  logic [15:0] bw = 16'd0, bh = 16'd0;
  logic [7:0] sd_data = 8'd0;
  logic sd_dv = 1'b0, sd_end = 1'b0;
  logic ready0, nf0, wr0, rd0, pv0, eol0, ready1, nf1, wr1, rd1, pv1, eol1;
  logic [2:0] sc0, sc1;
  logic [31:0] ad0, ad1;
  logic [23:0] pd0, pd1;
  int sel = 0;
  logic s_read, s_pv, s_eol, s_ready, s_nf, o_pv;
  logic [2:0] s_sc;
  logic [31:0] s_addr;
  logic [23:0] s_pd;
  assign s_read = sel != 0 ? rd1 : rd0;
  assign s_pv = sel != 0 ? pv1 : pv0;
  assign o_pv = sel != 0 ? pv0 : pv1;
  assign s_eol = sel != 0 ? eol1 : eol0;
  assign s_ready = sel != 0 ? ready1 : ready0;
  assign s_nf = sel != 0 ? nf1 : nf0;
  assign s_sc = sel != 0 ? sc1 : sc0;
  assign s_addr = sel != 0 ? ad1 : ad0;
  assign s_pd = sel != 0 ? pd1 : pd0;
  bmp_stream_reader #(.MAX_PROBES(4)) dut0 (
    .clk(clk), .rst(rst), .sd_init_done(init), .find(find0), .bmp_width(bw), .bmp_height(bh),
    .ready(ready0), .state_code(sc0), .not_found(nf0), .write_req(wr0), .write_req_ack(ack0),
    .sd_sec_read(rd0), .sd_sec_read_addr(ad0), .sd_sec_read_data(sd_data),
    .sd_sec_read_data_valid(sd_dv), .sd_sec_read_end(sd_end),
    .pix_valid(pv0), .pix_data(pd0), .pix_eol(eol0));
  bmp_stream_reader #(.MAX_PROBES(4), .OUT_RGB565(1)) dut1 (
    .clk(clk), .rst(rst), .sd_init_done(init), .find(find1), .bmp_width(bw), .bmp_height(bh),
    .ready(ready1), .state_code(sc1), .not_found(nf1), .write_req(wr1), .write_req_ack(ack1),
    .sd_sec_read(rd1), .sd_sec_read_addr(ad1), .sd_sec_read_data(sd_data),
    .sd_sec_read_data_valid(sd_dv), .sd_sec_read_end(sd_end),
    .pix_valid(pv1), .pix_data(pd1), .pix_eol(eol1));
  typedef struct packed {logic [23:0] d; logic eol;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [7:0] mem [int];
  int nsec = 0;
  logic [31:0] secs[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (o_pv) begin
      checks++;
      errors++;
      $display("FAIL idle dut pixel: got pix_valid 1, expected 0");
    end
    if (s_pv) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected pixel: got %0h, expected none", s_pd);
      end else begin
        e = q.pop_front();
        chk("pix_data", 32'(s_pd), 32'(e.d));
        chk("pix_eol", 32'(s_eol), 32'(e.eol));
      end
    end
  end
  int base;
  initial forever begin
    @(negedge clk);
    if (s_read) begin
      base = int'(s_addr) * 512;
      secs.push_back(s_addr);
      nsec++;
      for (int i = 0; i < 512 && s_read; i++) begin
        sd_dv = 1'b1;
        sd_data = mem.exists(base + i) ? mem[base + i] : 8'h00;
        @(negedge clk);
      end
      sd_dv = 1'b0;
      if (s_read) begin
        sd_end = 1'b1;
        @(negedge clk);
        sd_end = 1'b0;
      end
      while (s_read) @(negedge clk);
    end
  end
  initial forever begin
    @(negedge clk);
    ack0 = wr0 && !ack0;
    ack1 = wr1 && !ack1;
  end
  task automatic put32(input int a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) mem[a + k] = v[8*k +: 8];
  endtask
  task automatic put_bmp(input int sec, input int w, input int h, input int bpp, input int off, input bit rgb);
    int b0, ha, rp, rb, a, p;
    logic [7:0] b, g, r;
    exp_t x;
    b0 = sec * 512;
    ha = h < 0 ? -h : h;
    rp = w * bpp / 8;
    rb = (rp + 3) / 4 * 4;
    mem[b0] = 8'h42;
    mem[b0 + 1] = 8'h4D;
    put32(b0 + 2, 32'(off + rb * ha));
    put32(b0 + 10, 32'(off));
    put32(b0 + 18, 32'(w));
    put32(b0 + 22, 32'(h));
    mem[b0 + 28] = 8'(bpp);
    mem[b0 + 29] = 8'h00;
    p = 0;
    for (int y = 0; y < ha; y++) begin
      a = b0 + off + y * rb;
      for (int xx = 0; xx < w; xx++) begin
        b = 8'h11 + 8'(p);
        g = 8'h22 + 8'(p);
        r = 8'h33 + 8'(p);
        mem[a] = b;
        mem[a + 1] = g;
        mem[a + 2] = r;
        a += 3;
        if (bpp == 32) begin
          mem[a] = 8'hAA;
          a++;
        end
        x.d = rgb ? {8'd0, r[7:3], g[7:2], b[7:3]} : {r, g, b};
        x.eol = xx == w - 1;
        q.push_back(x);
        p++;
      end
      for (int k = rp; k < rb; k++) begin
        mem[a] = 8'hEE;
        a++;
      end
    end
  endtask
  task automatic start(input int s, input int w, input int h);
    sel = s;
    bw = 16'(w);
    bh = 16'(h);
    nsec = 0;
    secs.delete();
    @(negedge clk);
    if (s != 0) find1 = 1'b1;
    else find0 = 1'b1;
    @(negedge clk);
    find0 = 1'b0;
    find1 = 1'b0;
  endtask
  task automatic run(input int s, input int w, input int h, input string tag);
    int n;
    start(s, w, h);
    n = 0;
    while ((q.size() != 0 || !s_ready) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " finished in budget"}, 32'(n < 8000), 32'd1);
    chk({tag, " addr back to start"}, s_addr, 32'd32000);
    chk({tag, " state_code idle"}, 32'(s_sc), 32'd1);
  endtask
  exp_t t;
  int n;
  initial begin
    repeat (3) @(negedge clk);
    chk("reset state_code", 32'(sc0), 32'd0);
    chk("reset ready", 32'(ready0), 32'd0);
    chk("reset addr", ad0, 32'd32000);
    chk("reset outputs", {28'd0, rd0, wr0, pv0, nf0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle ready", 32'(ready0), 32'd1);
    chk("idle state_code", 32'(sc0), 32'd1);
    mem.delete();
    put_bmp(32016, 4, 2, 24, 54, 1'b0);
    run(0, 4, 2, "t1");
    chk("t1 sectors read", 32'(nsec), 32'd4);
    if (secs.size() >= 4) begin
      chk("t1 probe0", secs[0], 32'd32000);
      chk("t1 probe1", secs[1], 32'd32008);
      chk("t1 probe2", secs[2], 32'd32016);
      chk("t1 reread", secs[3], 32'd32016);
    end
    mem.delete();
    put_bmp(32024, 3, 2, 24, 54, 1'b0);
    run(0, 3, 2, "t2");
    mem.delete();
    put_bmp(32008, 4, -2, 32, 138, 1'b0);
    run(0, 4, 2, "t3");
    mem.delete();
    put_bmp(32000, 2, 1, 24, 54, 1'b1);
    mem[32000 * 512 + 54] = 8'h08;
    mem[32000 * 512 + 55] = 8'h80;
    mem[32000 * 512 + 56] = 8'hFF;
    t = q.pop_front();
    t.d = 24'h00FC01;
    q.push_front(t);
    run(1, 2, 1, "t4");
    mem.delete();
    start(0, 4, 2);
    n = 0;
    while (!nf0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("t5 not_found seen", 32'(nf0), 32'd1);
    chk("t5 state_code", 32'(sc0), 32'd4);
    chk("t5 ready", 32'(ready0), 32'd1);
    chk("t5 addr", ad0, 32'd32000);
    chk("t5 probes", 32'(nsec), 32'd4);
    @(negedge clk);
    chk("t5 pulse width", 32'(nf0), 32'd0);
    chk("t5 state_code held", 32'(sc0), 32'd4);
    mem.delete();
    put_bmp(32000, 4, 2, 24, 54, 1'b0);
    start(0, 4, 2);
    n = 0;
    while (q.size() > 5 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("t6 pixels before drop", 32'(q.size() <= 5), 32'd1);
    init = 1'b0;
    q.delete();
    @(negedge clk);
    chk("t6 state_code", 32'(sc0), 32'd0);
    chk("t6 sd_sec_read", 32'(rd0), 32'd0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (rd0) n++;
    end
    chk("t6 read stays low", 32'(n), 32'd0);
    init = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6 ready again", 32'(ready0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bmp_stream_reader.md
Name: bmp_stream_reader

Overview:
Parametrised successor to the single-format BMP reader, placed between the SD sector reader and the frame-buffer write path. It searches the SD card on a sector stride for a BMP whose header matches the requested width and height. It parses the real pixel-data offset, handles 24 and 32 bpp and 4-byte row padding, and streams pixels as RGB888 or RGB565. Bounded search reports not-found instead of scanning forever.

Parameters:
START_SECTOR, 32000, first sector probed; forced to a multiple of SEARCH_STRIDE
SEARCH_STRIDE, 8, sectors between probes (power of 2)
MAX_PROBES, 4096, probes before giving up
OUT_RGB565, 0, 1 = pix_data[15:0] holds RGB565 and [23:16] is 0

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sd_init_done  in  1  SD initialisation complete
find  in  1  start search (sampled in IDLE)
bmp_width  in  16  required width
bmp_height  in  16  required height (absolute value is compared)
ready  out  1  high in IDLE
state_code  out  3  0 init, 1 idle, 2 searching, 3 reading, 4 not found
not_found  out  1  one-cycle pulse on search exhaustion
write_req  out  1  frame write request
write_req_ack  in  1  frame write acknowledge
sd_sec_read  out  1  sector read request level
sd_sec_read_addr  out  32  sector address
sd_sec_read_data  in  8  sector byte
sd_sec_read_data_valid  in  1  byte strobe
sd_sec_read_end  in  1  sector done pulse
pix_valid  out  1  pixel strobe
pix_data  out  24  {R,G,B} or {8'd0,RGB565}
pix_eol  out  1  with pix_valid, last pixel of a row

Behaviour:
- Reset values: state IDLE; sd_sec_read_addr = START_SECTOR aligned down; state_code 0; every other output 0.
- If sd_init_done is low: state goes to IDLE, sd_sec_read 0, write_req 0, state_code 0, and any transfer is abandoned.
- IDLE: state_code 1 and ready 1. find=1 moves to FIND and clears the probe count.
- FIND: hold sd_sec_read 1. Count bytes 0..511 (10-bit). Capture little-endian fields:
  - bytes 0-1 magic
  - 2-5 file_len
  - 10-13 data_off
  - 18-21 width
  - 22-25 height (two's complement; the absolute value is taken)
  - 28-29 bpp
- On sd_sec_read_end, drop sd_sec_read and go to CHECK.
- CHECK (1 cycle): match when magic=="BM", width[15:0]==bmp_width, |height|[15:0]==bmp_height, bpp is 24 or 32, and 54<=data_off<file_len.
  - Match: raise write_req, go to WAIT_ACK, keep the address.
  - No match, probe count+1 < MAX_PROBES: address += SEARCH_STRIDE, back to FIND.
  - Otherwise: go to FAIL.
- FAIL: state_code 4, not_found pulse for 1 cycle, address reset to START_SECTOR, go to IDLE. state_code stays 4 until the next find.
- WAIT_ACK: on write_req_ack, clear write_req and go to READ.
- READ: state_code 3, sd_sec_read 1. The file is re-read from byte 0 of the found sector. A 32-bit byte counter increments per valid byte.
  - Bytes with counter < data_off are discarded.
  - Bytes after that form pixels in order B,G,R(,A); A is discarded.
  - row_bytes = width*bpp/8 rounded up to a multiple of 4. After the width pixels of a row, the pad bytes (row_bytes - width*bpp/8) are discarded.
  - pix_valid is registered, asserted the cycle after the byte completing a pixel. pix_eol is set on column == width-1.
  - RGB565 = {R[7:3],G[7:2],B[7:3]}.
- On each sd_sec_read_end in READ: address+1 and sd_sec_read low for 1 cycle.
  - Go to DONE when pixel count == width*height, or byte counter >= file_len, whichever comes first.
  - No pix_valid is issued after the final pixel, even if the sector still delivers bytes.
- DONE: address reset to START_SECTOR, go to IDLE.
- Counters (byte, pad, column, pixel) clear on entry to READ.
- find is ignored outside IDLE.
- Pixel products use 32-bit arithmetic.

Test Plan:
- 24bpp, 4x2, data_off 54, at START+16: 2 probes fail, 3rd matches; 8 pix_valid; pix_eol on 4th and 8th; first pixel bytes 0x11,0x22,0x33 -> pix_data 0x332211.
- 24bpp, width 3: 3 pad bytes per row discarded; exactly 3 pixels per row; pad values never appear on pix_data.
- 32bpp, data_off 138, height -2 (top-down): header matches; alpha bytes dropped; 8 pixels output.
- OUT_RGB565=1, pixel R=0xFF G=0x80 B=0x08 -> pix_data 0x00FC01.
- MAX_PROBES=4, no BMP present: 4 probes, then not_found pulse, state_code 4, ready 1, address = START_SECTOR.
- sd_init_done drops mid-READ: next cycle state IDLE, sd_sec_read 0, no further pix_valid.
